calc_entry_ctrl: RTL
====================

// Module: calc_entry_ctrl
// PURPOSE
//  Key-entry sequencer for the two-operand calculator datapath. Collects
//  keypad digit/operator codes into A1,A0,OP,B1,B0, and drives them to the
//  calculation block. On '=' it waits for the datapath to settle and
//  captures the result. It then presents the result as magnitude plus sign.
//  Sits between the keypad decoder and the calculation block/display.
// PARAMETERS
//  KEY_EQ    8'h0E  key code for '=' (start calculation)
//  KEY_CLR   8'h0C  key code for clear (abort, return to operand A entry)
//  CALC_LAT  2      cycles from entering CALC to capture of calc_out (>=1)
// PORTS
//  clk           in   1   system clock, rising edge
//  rst           in   1   reset, asynchronous, active-low
//  key_valid     in   1   one-cycle strobe: key_code is valid this cycle
//  key_code      in   8   digit 8'd0..8'd9, or `A_add/`B_sub/`f_mult, KEY_EQ, KEY_CLR
//  A1,A0         out  8   operand A tens/units digit (binary 0..9)
//  B1,B0         out  8   operand B tens/units digit (binary 0..9)
//  OP            out  8   latched operator code, to calculation OP
//  calc_out      in   14  calculation block result (14-bit, wraps on sub)
//  result        out  14  captured result magnitude
//  result_neg    out  1   captured result is negative (sub with A<B)
//  result_valid  out  1   one-cycle pulse when result/result_neg update
//  busy          out  1   high in CALC state
//  state         out  2   00 ENTER_A, 01 ENTER_B, 10 CALC, 11 SHOW
// BEHAVIOUR
//  Reset (rst=0, async): state=ENTER_A, all digits/OP/result=0,
//   result_neg=0, result_valid=0, busy=0, digit counters=0, CALC counter=0.
//  Keys act only on cycles with key_valid=1. Codes that are unrecognised or
//   illegal in the current state are ignored with no state change.
//  Digit entry (ENTER_A into A, ENTER_B into B), count n of entered digits:
//   n=0: X0<=d, X1<=0, n=1.  n=1: X1<=X0, X0<=d, n=2.  n=2: digit ignored.
//  ENTER_A: digit enters A. Operator (`A_add/`B_sub/`f_mult) with nA>=1:
//   OP<=code, go ENTER_B. Operator with nA=0 is ignored. KEY_EQ is ignored.
//  ENTER_B: digit enters B. KEY_EQ with nB>=1: go CALC, load counter=CALC_LAT.
//   An operator key is ignored, so OP stays as latched.
//  CALC: busy=1. All keys except KEY_CLR are ignored. The counter decrements
//   each cycle. On the cycle it reaches 0, capture calc_out and go SHOW.
//  Capture: aval=A1*10+A0, bval=B1*10+B0 (7-bit unsigned).
//   If OP==`B_sub and aval<bval: result_neg<=1, result<=(~calc_out+1)[13:0].
//   Otherwise: result_neg<=0, result<=calc_out.
//   result_valid=1 exactly in the cycle after capture (registered pulse).
//  Latency: KEY_EQ accepted at edge k; result valid at edge k+CALC_LAT+1.
//  SHOW: result holds. Digit key: clear A/B/OP, n counts=0, load the digit
//   as first digit of A, go ENTER_A. Operator and KEY_EQ are ignored.
//  KEY_CLR, any state including CALC: clear A/B/OP/counts and go ENTER_A.
//   result/result_neg are kept. CLR in CALC aborts: no capture, no
//   result_valid.
//  A1..B0/OP are registered and change only on accepted keys. They stay
//   stable throughout CALC.
//  Reset asserted mid-operation: immediate return to reset values. Any
//   pending capture is lost.
// TESTING
//  1,2,`A_add,3,4,EQ -> A1=1 A0=2 B1=3 B0=4; result=46 neg=0, pulse at k+3
//  5,`B_sub,1,7,EQ -> A0=5 B=17; calc_out=0x3FF4 -> result=12 neg=1
//  9,9,`f_mult,9,9,EQ -> result=9801 neg=0; busy high exactly CALC_LAT cycles
//  1,2,3 -> A1=1 A0=2 (third digit dropped); `A_add before any digit ignored
//  entry then EQ, CLR during CALC -> state=ENTER_A, no result_valid, old result kept
//  rst low during ENTER_B (async, mid-cycle) -> all outputs 0 immediately

Source files
------------

// File: rtl/calc_entry_ctrl.sv
// ---------------------------------------------------------------------------
// calc_entry_ctrl
//   Key-entry sequencer for the two-operand calculator. Collects up to two
//   decimal digits for operand A, an operator, then up to two digits for
//   operand B. On '=' it holds the operands stable while the calculation
//   block settles, then captures the result as magnitude plus sign.
//
// Ports
//   clk           in   1   system clock, rising edge
//   rst           in   1   asynchronous reset, active-low
//   key_valid     in   1   key_code is valid this cycle
//   key_code      in   8   digit 0..9, operator, KEY_EQ or KEY_CLR
//   A1, A0        out  8   operand A tens / units digit
//   B1, B0        out  8   operand B tens / units digit
//   OP            out  8   latched operator code
//   calc_out      in   14  calculation block result
//   result        out  14  captured result magnitude
//   result_neg    out  1   captured result is negative
//   result_valid  out  1   one-cycle pulse when result/result_neg update
//   busy          out  1   high while waiting for the datapath
//   state         out  2   00 ENTER_A, 01 ENTER_B, 10 CALC, 11 SHOW
// ---------------------------------------------------------------------------
module calc_entry_ctrl #(
    parameter logic [7:0] KEY_EQ   = 8'h0E,
    parameter logic [7:0] KEY_CLR  = 8'h0C,
    parameter logic [7:0] KEY_ADD  = 8'h0A,
    parameter logic [7:0] KEY_SUB  = 8'h0B,
    parameter logic [7:0] KEY_MULT = 8'h0F,
    parameter int         CALC_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    output logic [7:0]  A1,
    output logic [7:0]  A0,
    output logic [7:0]  B1,
    output logic [7:0]  B0,
    output logic [7:0]  OP,
    input  logic [13:0] calc_out,
    output logic [13:0] result,
    output logic        result_neg,
    output logic        result_valid,
    output logic        busy,
    output logic [1:0]  state
);

    localparam int CW = $clog2(CALC_LAT + 1);

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        CALC    = 2'b10,
        SHOW    = 2'b11
    } state_t;

    state_t          cur_q, nxt;
    logic [1:0]      na_q, na_n, nb_q, nb_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [7:0]      a1_n, a0_n, b1_n, b0_n, op_n;
    logic [13:0]     result_n;
    logic            neg_n;
    logic            capture;
    logic            is_digit, is_op, is_eq, is_clr;
    logic [6:0]      aval, bval;

    assign is_digit = key_valid && (key_code <= 8'd9);
    assign is_op    = key_valid && (key_code == KEY_ADD || key_code == KEY_SUB ||
                                    key_code == KEY_MULT);
    assign is_eq    = key_valid && (key_code == KEY_EQ);
    assign is_clr   = key_valid && (key_code == KEY_CLR);

    // Digits are 0..9, so the two-digit value never exceeds 99.
    assign aval = 7'(A1 * 8'd10 + A0);
    assign bval = 7'(B1 * 8'd10 + B0);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        nxt      = cur_q;
        na_n     = na_q;
        nb_n     = nb_q;
        cnt_n    = cnt_q;
        a1_n     = A1;
        a0_n     = A0;
        b1_n     = B1;
        b0_n     = B0;
        op_n     = OP;
        result_n = result;
        neg_n    = result_neg;
        capture  = 1'b0;

        if (is_clr) begin
            // Clear wins in every state; the last result stays on display.
            nxt  = ENTER_A;
            na_n = 2'd0;
            nb_n = 2'd0;
            a1_n = 8'd0;
            a0_n = 8'd0;
            b1_n = 8'd0;
            b0_n = 8'd0;
            op_n = 8'd0;
        end else begin
            case (cur_q)
                ENTER_A: begin
                    if (is_digit) begin
                        if (na_q == 2'd0) begin
                            a1_n = 8'd0;
                            a0_n = key_code;
                            na_n = 2'd1;
                        end else if (na_q == 2'd1) begin
                            a1_n = A0;
                            a0_n = key_code;
                            na_n = 2'd2;
                        end
                    end else if (is_op && na_q != 2'd0) begin
                        op_n = key_code;
                        nxt  = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (is_digit) begin
                        if (nb_q == 2'd0) begin
                            b1_n = 8'd0;
                            b0_n = key_code;
                            nb_n = 2'd1;
                        end else if (nb_q == 2'd1) begin
                            b1_n = B0;
                            b0_n = key_code;
                            nb_n = 2'd2;
                        end
                    end else if (is_eq && nb_q != 2'd0) begin
                        cnt_n = CW'(CALC_LAT);
                        nxt   = CALC;
                    end
                end
                CALC: begin
                    // The edge that takes the counter to zero is the capture edge.
                    cnt_n = cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) begin
                        capture = 1'b1;
                        nxt     = SHOW;
                    end
                end
                SHOW: begin
                    if (is_digit) begin
                        a1_n = 8'd0;
                        a0_n = key_code;
                        b1_n = 8'd0;
                        b0_n = 8'd0;
                        op_n = 8'd0;
                        na_n = 2'd1;
                        nb_n = 2'd0;
                        nxt  = ENTER_A;
                    end
                end
                default: nxt = ENTER_A;
            endcase
        end

        if (capture) begin
            // The datapath wraps on a negative difference; undo the two's complement.
            if (OP == KEY_SUB && aval < bval) begin
                neg_n    = 1'b1;
                result_n = 14'(~calc_out + 14'd1);
            end else begin
                neg_n    = 1'b0;
                result_n = calc_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_q        <= ENTER_A;
            na_q         <= 2'd0;
            nb_q         <= 2'd0;
            cnt_q        <= '0;
            A1           <= 8'd0;
            A0           <= 8'd0;
            B1           <= 8'd0;
            B0           <= 8'd0;
            OP           <= 8'd0;
            result       <= 14'd0;
            result_neg   <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cur_q        <= nxt;
            na_q         <= na_n;
            nb_q         <= nb_n;
            cnt_q        <= cnt_n;
            A1           <= a1_n;
            A0           <= a0_n;
            B1           <= b1_n;
            B0           <= b0_n;
            OP           <= op_n;
            result       <= result_n;
            result_neg   <= neg_n;
            result_valid <= capture;
        end
    end

    assign busy  = (cur_q == CALC);
    assign state = cur_q;

endmodule
